// File: rtl/vid_timing_meas_if.sv
// Video sync/blank bundle carried from a video source into the timing
// measurement block. All signals share the dot-clock domain.
interface vid_timing_meas_if;
  logic HSYNC_N;
  logic VSYNC_N;
  logic BLANK_N;

  modport master (output HSYNC_N, output VSYNC_N, output BLANK_N);
  modport slave  (input  HSYNC_N, input  VSYNC_N, input  BLANK_N);
endinterface

// File: rtl/vid_timing_meas.sv
// Display timing measurement: measures horizontal and vertical timing of an
// incoming sync/blank stream every frame, publishes the eight measurements as
// one coherent set and flags LOCKED once consecutive frames agree.
module vid_timing_meas #(
  parameter logic [15:0] LOCK_FRAMES = 16'd2,
  parameter logic [15:0] TIMEOUT     = 16'd4096
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  vid_timing_meas_if.slave        vid,
  output logic [15:0]             H_TOTAL,
  output logic [15:0]             H_SYNC,
  output logic [15:0]             H_START,
  output logic [15:0]             H_ACTIVE,
  output logic [15:0]             V_TOTAL,
  output logic [15:0]             V_SYNC,
  output logic [15:0]             V_START,
  output logic [15:0]             V_ACTIVE,
  output logic                    MEAS_VALID,
  output logic                    LOCKED
);

  typedef enum logic [1:0] {IDLE, MEAS, TRACK} state_t;

  state_t state_q, state_d;

  logic hs_r1_q, hs_r2_q, vs_r1_q, vs_r2_q, bl_r1_q, bl_r2_q;
  logic hs_fall, hs_rise, vs_fall, vs_rise, bl_rise, bl_fall, timeout;

  logic [15:0] hcnt_q, vcnt_q, actcnt_q;
  logic [15:0] line_total_q, line_sync_q, line_start_q, line_active_q;
  logic [15:0] frame_sync_q, frame_start_q;
  logic        line_act_q, frame_act_q;

  logic [127:0] snap_q, meas_q;
  logic         pub_q, base_q, valid_q;
  logic [15:0]  match_q;

  assign hs_fall = hs_r2_q & ~hs_r1_q;
  assign hs_rise = ~hs_r2_q & hs_r1_q;
  assign vs_fall = vs_r2_q & ~vs_r1_q;
  assign vs_rise = ~vs_r2_q & vs_r1_q;
  assign bl_rise = ~bl_r2_q & bl_r1_q;
  assign bl_fall = bl_r2_q & ~bl_r1_q;
  assign timeout = (hcnt_q == TIMEOUT);

  // Two-stage input pipeline; sync idles high and blank low so reset makes no edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hs_r1_q <= 1'b1;
      hs_r2_q <= 1'b1;
      vs_r1_q <= 1'b1;
      vs_r2_q <= 1'b1;
      bl_r1_q <= 1'b0;
      bl_r2_q <= 1'b0;
    end else begin
      hs_r1_q <= vid.HSYNC_N;
      hs_r2_q <= hs_r1_q;
      vs_r1_q <= vid.VSYNC_N;
      vs_r2_q <= vs_r1_q;
      bl_r1_q <= vid.BLANK_N;
      bl_r2_q <= bl_r1_q;
    end
  end

  // Line and frame counters plus per-line / per-frame captures
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      actcnt_q      <= '0;
      line_total_q  <= '0;
      line_sync_q   <= '0;
      line_start_q  <= '0;
      line_active_q <= '0;
      line_act_q    <= 1'b0;
      frame_sync_q  <= '0;
      frame_start_q <= '0;
      frame_act_q   <= 1'b0;
    end else begin
      if (hs_fall)
        hcnt_q <= 16'd1;
      else if (hcnt_q != '1)
        hcnt_q <= hcnt_q + 16'd1;

      if (timeout) begin
        vcnt_q        <= '0;
        actcnt_q      <= '0;
        line_total_q  <= '0;
        line_sync_q   <= '0;
        line_start_q  <= '0;
        line_active_q <= '0;
        line_act_q    <= 1'b0;
        frame_sync_q  <= '0;
        frame_start_q <= '0;
        frame_act_q   <= 1'b0;
      end else begin
        if (hs_fall) begin
          line_total_q <= hcnt_q;
          line_act_q   <= 1'b0;
        end
        if (hs_rise)
          line_sync_q <= hcnt_q;
        if (bl_rise && !line_act_q && !hs_fall) begin
          line_start_q <= hcnt_q;
          line_act_q   <= 1'b1;
          if (actcnt_q != '1)
            actcnt_q <= actcnt_q + 16'd1;
          if (!frame_act_q) begin
            frame_start_q <= vcnt_q - 16'd1;
            frame_act_q   <= 1'b1;
          end
        end
        if (bl_fall && line_act_q)
          line_active_q <= hcnt_q - line_start_q;

        if (vs_fall)
          vcnt_q <= hs_fall ? 16'd1 : 16'd0;
        else if (hs_fall && vcnt_q != '1)
          vcnt_q <= vcnt_q + 16'd1;
        if (vs_rise)
          frame_sync_q <= vcnt_q;
        // Frame-level clears override any same-cycle line update
        if (vs_fall) begin
          actcnt_q    <= '0;
          frame_act_q <= 1'b0;
        end
      end
    end
  end

  // Snapshot of pre-update values on vs_fall; published one cycle later
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      snap_q <= '0;
      pub_q  <= 1'b0;
      base_q <= 1'b0;
    end else begin
      pub_q <= 1'b0;
      if (!timeout && vs_fall && state_q != IDLE) begin
        pub_q  <= 1'b1;
        base_q <= (state_q == MEAS);
        snap_q <= {line_total_q, line_sync_q, line_start_q, line_active_q,
                   vcnt_q, frame_sync_q, frame_start_q, actcnt_q};
      end
    end
  end

  // Atomic publish of all eight outputs and frame-to-frame match tracking
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meas_q  <= '0;
      valid_q <= 1'b0;
      match_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (timeout) begin
        match_q <= '0;
      end else if (pub_q) begin
        meas_q  <= snap_q;
        valid_q <= 1'b1;
        if (base_q || snap_q != meas_q)
          match_q <= '0;
        else if (match_q < LOCK_FRAMES)
          match_q <= match_q + 16'd1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // FSM next-state: advance on vs_fall, loss of signal returns to IDLE
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (vs_fall) begin
      case (state_q)
        IDLE:    state_d = MEAS;
        MEAS:    state_d = TRACK;
        default: state_d = TRACK;
      endcase
    end
  end

  // FSM output: lock indication
  always_comb begin
    LOCKED = (state_q == TRACK) && (match_q == LOCK_FRAMES);
  end

  assign {H_TOTAL, H_SYNC, H_START, H_ACTIVE,
          V_TOTAL, V_SYNC, V_START, V_ACTIVE} = meas_q;
  assign MEAS_VALID = valid_q;

endmodule

// File: tb/tb_vid_timing_meas.sv
// Directed-sequence bench with randomized frame geometry for vid_timing_meas.
module tb_vid_timing_meas;

  localparam logic [15:0] LF = 16'd2;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  vid_timing_meas_if vif();

  logic [15:0] H_TOTAL, H_SYNC, H_START, H_ACTIVE;
  logic [15:0] V_TOTAL, V_SYNC, V_START, V_ACTIVE;
  logic        MEAS_VALID, LOCKED;
  logic [127:0] outs;

  assign outs = {H_TOTAL, H_SYNC, H_START, H_ACTIVE, V_TOTAL, V_SYNC, V_START, V_ACTIVE};

  vid_timing_meas #(.LOCK_FRAMES(LF), .TIMEOUT(16'd4096)) dut (
    .CLK(CLK), .RST_N(RST_N), .vid(vif),
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_START(H_START), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_START(V_START), .V_ACTIVE(V_ACTIVE),
    .MEAS_VALID(MEAS_VALID), .LOCKED(LOCKED)
  );

  // Frame geometry: line length, sync width, blank start/width, lines per
  // frame, vsync lines, active line range, vsync offset within line 0.
  // c* fields carry the last active-line measurements seen before this frame.
  typedef struct {
    int L, hsw, bst, bw, n, vsl, ast, aen, vo;
    bit blank;
    int cst, cact, cvst;
  } geom_t;

  int checks = 0;
  int errors = 0;
  int mon_cnt = 0;
  logic [127:0] mon_vec = '0;
  logic         mon_lock = 1'b0;

  int vs_cnt;
  int last_st, last_act, last_vst;
  logic [127:0] hist[$];
  geom_t prev, g0, g1, gm, gb, gr;

  // Record every publish pulse with the outputs and lock flag of that cycle
  always @(negedge CLK) begin
    if (MEAS_VALID === 1'b1) begin
      mon_cnt++;
      mon_vec = outs;
      mon_lock = LOCKED;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic geom_t rand_geom();
    geom_t g;
    g.L     = 24 + int'($urandom_range(0, 16));
    g.hsw   = 2 + int'($urandom_range(0, 3));
    g.bst   = g.hsw + 2 + int'($urandom_range(0, 3));
    g.bw    = int'($urandom_range(4, g.L - g.bst - 2));
    g.n     = 12 + int'($urandom_range(0, 8));
    g.vsl   = 2 + int'($urandom_range(0, 2));
    g.ast   = g.vsl + 1 + int'($urandom_range(0, 2));
    g.aen   = int'($urandom_range(g.ast + 1, g.n - 2));
    g.vo    = 0;
    g.blank = 1'b1;
    g.cst = 0; g.cact = 0; g.cvst = 0;
    return g;
  endfunction

  // Measurements reported for frame f when the following frame nx begins.
  // V_TOTAL counts hsync falls from f's vsync fall up to (not including one
  // coincident with) nx's vsync fall; a mid-line vsync shifts line indices.
  function automatic logic [127:0] expect_of(geom_t f, geom_t nx);
    int hst, hact, vtot, vst, vact;
    hst  = f.blank ? f.bst : f.cst;
    hact = f.blank ? f.bw  : f.cact;
    vst  = f.blank ? (f.ast - ((f.vo > 0) ? 1 : 0)) : f.cvst;
    vact = f.blank ? (f.aen - f.ast + 1) : 0;
    vtot = f.n - 1 + ((f.vo == 0) ? 1 : 0) + ((nx.vo > 0) ? 1 : 0);
    return {16'(f.L), 16'(f.hsw), 16'(hst), 16'(hact),
            16'(vtot), 16'(f.vsl), 16'(vst), 16'(vact)};
  endfunction

  // Locked when the latest LOCK_FRAMES+1 publishes are identical
  function automatic logic lock_exp();
    int lfi;
    lfi = int'(LF);
    if (hist.size() < lfi + 1) return 1'b0;
    for (int i = 1; i <= lfi; i++)
      if (hist[hist.size() - 1 - i] !== hist[hist.size() - 1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_frame(input geom_t g, input int stop);
    for (int ln = 0; ln < g.n && ln < stop; ln++) begin
      for (int t = 0; t < g.L; t++) begin
        int pos;
        pos = ln * g.L + t;
        @(negedge CLK);
        vif.HSYNC_N = (t < g.hsw) ? 1'b0 : 1'b1;
        vif.VSYNC_N = (pos >= g.vo && pos < g.vsl * g.L + g.vo) ? 1'b0 : 1'b1;
        vif.BLANK_N = (g.blank && ln >= g.ast && ln <= g.aen &&
                       t >= g.bst && t < g.bst + g.bw) ? 1'b1 : 1'b0;
      end
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      vif.HSYNC_N = 1'b1;
      vif.VSYNC_N = 1'b1;
      vif.BLANK_N = 1'b0;
    end
  endtask

  task automatic model_restart();
    vs_cnt = 0;
    hist.delete();
    last_st = 0; last_act = 0; last_vst = 0;
  endtask

  task automatic step(input string tag, input geom_t gi, input int stop);
    geom_t g;
    logic [127:0] e;
    bit pub;
    int c0;
    g = gi;
    g.cst = last_st; g.cact = last_act; g.cvst = last_vst;
    vs_cnt++;
    pub = (vs_cnt >= 2);
    e = '0;
    if (pub) begin
      e = expect_of(prev, g);
      hist.push_back(e);
    end
    c0 = mon_cnt;
    drive_frame(g, stop);
    if (g.blank) begin
      last_st = g.bst; last_act = g.bw;
      last_vst = g.ast - ((g.vo > 0) ? 1 : 0);
    end
    chk({tag, "_pulses"}, 128'(mon_cnt - c0), 128'(pub ? 1 : 0));
    if (pub) begin
      chk({tag, "_meas"}, mon_vec, e);
      chk({tag, "_lock_at_pub"}, 128'(mon_lock), 128'(lock_exp()));
    end
    chk({tag, "_lock"}, 128'(LOCKED), 128'(lock_exp()));
    prev = g;
  endtask

  initial begin
    logic [127:0] held;
    int c0;
    vif.HSYNC_N = 1'b1;
    vif.VSYNC_N = 1'b1;
    vif.BLANK_N = 1'b0;
    RST_N = 1'b0;
    model_restart();
    repeat (3) @(negedge CLK);
    chk("reset_outs", outs, 128'd0);
    chk("reset_valid", 128'(MEAS_VALID), 128'd0);
    chk("reset_lock", 128'(LOCKED), 128'd0);
    RST_N = 1'b1;
    idle(5);

    // Steady stream: baseline at 2nd vsync fall, lock at 4th
    g0 = rand_geom();
    for (int i = 0; i < 5; i++) step("steady", g0, 1 << 30);

    // One frame with longer lines breaks lock; two matches restore it
    g1 = g0;
    g1.L = g0.L + 1;
    step("long_line", g1, 1 << 30);
    for (int i = 0; i < 4; i++) step("relock", g0, 1 << 30);

    // Vsync falling mid-line
    gm = g0;
    gm.vo = g0.L / 2;
    for (int i = 0; i < 4; i++) step("midline", gm, 1 << 30);
    for (int i = 0; i < 4; i++) step("back_aligned", g0, 1 << 30);

    // Frame with no active pixels
    gb = g0;
    gb.blank = 1'b0;
    step("noblank", gb, 1 << 30);
    for (int i = 0; i < 5; i++) step("after_noblank", g0, 1 << 30);

    // Loss of hsync while locked: lock held until the timeout, outputs held
    chk("pre_timeout_lock", 128'(LOCKED), 128'd1);
    held = hist[hist.size() - 1];
    c0 = mon_cnt;
    idle(4090 - g0.L);
    chk("timeout_not_yet", 128'(LOCKED), 128'd1);
    idle(15);
    chk("timeout_lock", 128'(LOCKED), 128'd0);
    chk("timeout_hold", outs, held);
    chk("timeout_no_pulse", 128'(mon_cnt - c0), 128'd0);
    model_restart();
    for (int i = 0; i < 4; i++) step("resume", g0, 1 << 30);

    // Reset in the middle of a locked frame
    chk("pre_reset_lock", 128'(LOCKED), 128'd1);
    step("partial", g0, g0.n / 2);
    #2 RST_N = 1'b0;
    #1;
    chk("midreset_outs", outs, 128'd0);
    chk("midreset_lock", 128'(LOCKED), 128'd0);
    chk("midreset_valid", 128'(MEAS_VALID), 128'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    model_restart();
    idle(3);
    for (int i = 0; i < 4; i++) step("post_reset", g0, 1 << 30);

    // Fresh random geometry every frame
    for (int i = 0; i < 5; i++) begin
      gr = rand_geom();
      step("random", gr, 1 << 30);
    end
    step("random_tail", gr, 1 << 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vid_timing_meas.md
# vid_timing_meas

Display timing measurement block: the receive-side counterpart of the display timing generator. It sits on a dot-clock video input (HSYNC_N/VSYNC_N/BLANK_N, same clock domain) and measures horizontal and vertical timing every frame. It publishes the measurements as one coherent set, and asserts LOCKED once consecutive frames agree. Downstream capture/scaler logic uses the outputs to configure itself.

## Interface
- LOCK_FRAMES, 16'd2: number of consecutive matching publishes, after the baseline publish, required for LOCKED.
- TIMEOUT, 16'd4096: cycles without an HSYNC_N falling edge before the block declares loss of signal.

- CLK  in  1  dot clock.
- RST_N  in  1  reset, asynchronous, active-low.
- HSYNC_N  in  1  horizontal sync, active low.
- VSYNC_N  in  1  vertical sync, active low.
- BLANK_N  in  1  display enable; 1 = active pixel.
- H_TOTAL / H_SYNC / H_START / H_ACTIVE  out  16 each  cycles per line / sync width / sync fall to first active pixel / active pixels.
- V_TOTAL / V_SYNC / V_START / V_ACTIVE  out  16 each  lines per frame / sync lines / first active line index / active lines.
- MEAS_VALID  out  1  one-cycle pulse when the eight outputs update.
- LOCKED  out  1  timing stable.

## Operation
- Input stage: HSYNC_N, VSYNC_N, BLANK_N registered once (d), then again (q). Edges are decoded from d vs q. Reset values: sync registers 1, blank registers 0, so reset never creates a false edge.
- hcnt (16-bit): increments every cycle and saturates at 16'hFFFF. On hs_fall it loads 1.
- Per-line captures, using the hcnt value in the edge cycle:
  - hs_fall: line_total = hcnt.
  - hs_rise: line_sync = hcnt.
  - First bl_rise after hs_fall: line_start = hcnt, and the line is flagged active.
  - bl_fall: line_active = hcnt − line_start (16-bit wrap).
  - Later bl_rise events in the same line are ignored.
- vcnt (16-bit, saturating): increments on each hs_fall.
- On vs_fall:
  - frame_total = vcnt, using the pre-increment value.
  - vcnt loads 1 if hs_fall occurs in the same cycle, else 0.
- On vs_rise: frame_sync = vcnt, using the pre-increment value.
- First active-flagged line in a frame: frame_start = vcnt − 1.
- actcnt: counts lines containing a bl_rise. It is captured as V_ACTIVE, then cleared, on vs_fall.
- Horizontal outputs come from the last line before vs_fall. H_START and H_ACTIVE come from the last active line.
- State machine:
  - IDLE: no vs_fall seen yet. vs_fall → MEAS.
  - MEAS: first frame in progress. The next vs_fall publishes the baseline, clears match_cnt to 0, and moves to TRACK.
  - TRACK: each vs_fall publishes. If all eight new values equal the currently published values, match_cnt increments, saturating at LOCK_FRAMES. Otherwise match_cnt clears to 0.
- LOCKED = 1 when in TRACK and match_cnt == LOCK_FRAMES.
- Timeout: hcnt == TIMEOUT in any state →
  - state goes to IDLE;
  - match_cnt and LOCKED clear;
  - outputs hold their last published values;
  - all per-line and per-frame accumulators clear.
- Simultaneous events: vs_fall in the same cycle as hs_fall is legal and normal. The line capture and frame publish both use pre-update register values.

## Timing
- Reset values: all 16-bit outputs 0, MEAS_VALID 0, LOCKED 0, state IDLE. Counters reset to 0.
- Latency: VSYNC_N first sampled low at edge k → outputs and MEAS_VALID updated at edge k+2. LOCKED updates at the same edge.
- Measurement values are unaffected by the pipeline, because all inputs share the same delay.
- Publish is atomic: all eight outputs change on the same edge. MEAS_VALID is high for exactly that one cycle.
- LOCKED deassertion on a mismatching frame occurs on the same edge as the new values appear.
- Reset mid-frame: the next vs_fall after reset only enters MEAS. No publish occurs before the second vs_fall.

## Test plan
- 800-cycle lines; HSYNC low 32 cycles; BLANK_N high from hcnt 120 for 640 cycles. 511-line frames; VSYNC low lines 0–3, coincident with hs_fall; active lines 20–499.
  - Required: H_TOTAL 800, H_SYNC 32, H_START 120, H_ACTIVE 640, V_TOTAL 511, V_SYNC 4, V_START 20, V_ACTIVE 480.
  - First MEAS_VALID at the 2nd vs_fall; LOCKED=1 at the 4th vs_fall.
- Locked stream, then one frame with 801-cycle lines → at that frame's publish, H_TOTAL=801 and LOCKED=0. Return to 800 → LOCKED=1 again after 2 further matching frames.
- Stop HSYNC_N toggling while locked → LOCKED=0 exactly 4096 − hcnt-at-stop cycles later; outputs keep 800/511 values; 2nd subsequent vs_fall republishes.
- VSYNC_N falling mid-line (hcnt=400) instead of at hs_fall → V_TOTAL still 511 frame-to-frame; vcnt reload = 0 path exercised.
- Assert RST_N mid-frame while LOCKED → all outputs 0 immediately, no MEAS_VALID until the 2nd vs_fall after release.
- Frame with BLANK_N never high → V_ACTIVE=0; H_START and H_ACTIVE keep the prior active-line values; mismatch drops LOCKED.
